accel_job_scheduler: RTL and testbench

Round-robin job scheduler that shares one single-shot accelerator wrapper (read-buffer / HLS-kernel / write-back unit with `read_base`, `write_base`, `num_read`, `done`, `returnvalue`) between NREQ requesters. It latches the winning requester's descriptor and drives it to the wrapper. It holds the wrapper in reset between jobs, because the wrapper parks in SUSPEND after each job. It then releases the wrapper, waits for `done` under a watchdog, and returns the result with a one-cycle acknowledge.

---
 rtl/accel_job_scheduler.sv | 145 ++++++++++++++
 tb/tb_accel_job_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/accel_job_scheduler.sv
// Round-robin scheduler sharing one single-shot accelerator wrapper between NREQ requesters.
// The wrapper is held in reset between jobs and each run is guarded by a watchdog.
module accel_job_scheduler #(
   parameter int NREQ       = 4,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 65535
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [64*NREQ-1:0]   req_read_base,
   input  logic [64*NREQ-1:0]   req_write_base,
   input  logic [64*NREQ-1:0]   req_num,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      ack,
   output logic [NREQ-1:0]      err,
   output logic [31:0]          result,
   output logic                 acc_reset,
   output logic [63:0]          acc_read_base,
   output logic [63:0]          acc_write_base,
   output logic [63:0]          acc_num_read,
   input  logic                 acc_done,
   input  logic [31:0]          acc_returnvalue,
   output logic                 busy,
   output logic [31:0]          job_count
);

   localparam int IDX_W = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, RSTA, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] last, owner, win;
   logic [NREQ-1:0]  win_onehot;
   logic [63:0]      sel_read_base, sel_write_base, sel_num;
   logic [31:0]      rst_cnt, wd_cnt;
   logic             rst_last, wd_expired;

   // Scan downward so the lowest rotation offset (closest to last+1) is the final assignment.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      win = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (req[(int'(last) + k) % NREQ]) win = IDX_W'((int'(last) + k) % NREQ);
      end
      win_onehot = NREQ'(1) << win;
   end

   always_comb begin
      sel_read_base  = '0;
      sel_write_base = '0;
      sel_num        = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (IDX_W'(i) == win) begin
            sel_read_base  = req_read_base[64*i +: 64];
            sel_write_base = req_write_base[64*i +: 64];
            sel_num        = req_num[64*i +: 64];
         end
      end
   end

   assign rst_last   = (rst_cnt == 32'(RST_CYCLES - 1));
   assign wd_expired = (wd_cnt == 32'(TIMEOUT - 1));
   assign busy       = (state != IDLE);

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (|req) state_next = (sel_num == '0) ? DONE : RSTA;
         RSTA:    if (rst_last) state_next = RUN;
         RUN:     if (acc_done || wd_expired) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         last           <= IDX_W'(NREQ - 1);
         owner          <= '0;
         gnt            <= '0;
         ack            <= '0;
         err            <= '0;
         result         <= '0;
         acc_reset      <= 1'b1;
         acc_read_base  <= '0;
         acc_write_base <= '0;
         acc_num_read   <= '0;
         job_count      <= '0;
         rst_cnt        <= '0;
         wd_cnt         <= '0;
      end else begin
         ack <= '0;
         err <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  owner          <= win;
                  gnt            <= win_onehot;
                  acc_read_base  <= sel_read_base;
                  acc_write_base <= sel_write_base;
                  acc_num_read   <= sel_num;
                  rst_cnt        <= '0;
                  // Empty jobs complete immediately without ever releasing the wrapper.
                  if (sel_num == '0) begin
                     result    <= '0;
                     ack       <= win_onehot;
                     job_count <= job_count + 32'd1;
                  end
               end
            end
            RSTA: begin
               rst_cnt <= rst_cnt + 32'd1;
               if (rst_last) begin
                  acc_reset <= 1'b0;
                  wd_cnt    <= '0;
               end
            end
            RUN: begin
               wd_cnt <= wd_cnt + 32'd1;
               if (acc_done) begin
                  result    <= acc_returnvalue;
                  ack       <= gnt;
                  job_count <= job_count + 32'd1;
               end else if (wd_expired) begin
                  err <= gnt;
               end
            end
            DONE: begin
               gnt       <= '0;
               acc_reset <= 1'b1;
               last      <= owner;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_accel_job_scheduler.sv
// Directed bench for accel_job_scheduler: a table of jobs run through one generic
// job task, plus hand-written reset sequences.
module tb_accel_job_scheduler;

   localparam int NREQ       = 4;
   localparam int RST_CYCLES = 2;
   localparam int TIMEOUT    = 24;

   logic                clk;
   logic                reset;
   logic [NREQ-1:0]     req;
   logic [64*NREQ-1:0]  req_read_base, req_write_base, req_num;
   logic [NREQ-1:0]     gnt, ack, err;
   logic [31:0]         result;
   logic                acc_reset;
   logic [63:0]         acc_read_base, acc_write_base, acc_num_read;
   logic                acc_done;
   logic [31:0]         acc_returnvalue;
   logic                busy;
   logic [31:0]         job_count;

   accel_job_scheduler #(
      .NREQ(NREQ), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset), .req(req),
      .req_read_base(req_read_base), .req_write_base(req_write_base), .req_num(req_num),
      .gnt(gnt), .ack(ack), .err(err), .result(result), .acc_reset(acc_reset),
      .acc_read_base(acc_read_base), .acc_write_base(acc_write_base), .acc_num_read(acc_num_read),
      .acc_done(acc_done), .acc_returnvalue(acc_returnvalue), .busy(busy), .job_count(job_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  req;
      logic [63:0] num;
      bit          drop;       // drop req and scramble descriptors after the grant
      int          delay;      // RUN edge carrying acc_done; -1 = never
      logic [31:0] ret;
      logic [3:0]  exp_gnt;
      bit          exp_err;
      logic [31:0] exp_result;
      logic [31:0] exp_count;
   } job_t;

   job_t jobs[11];
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   n;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_desc(input logic [63:0] num);
      for (int i = 0; i < NREQ; i++) begin
         req_read_base[64*i +: 64]  = 64'h1000 + 64'(i) * 64'h100;
         req_write_base[64*i +: 64] = 64'h2000 + 64'(i) * 64'h100;
         req_num[64*i +: 64]        = num;
      end
   endtask

   function automatic int idx_of(input logic [3:0] oh);
      for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
      return 0;
   endfunction

   // Starts with the scheduler idle at a falling edge; ends at the falling edge after DONE.
   task automatic run_job(input job_t j);
      int          cnt, cyc, w;
      bit          seen;
      logic [63:0] rb, wb;
      set_desc(j.num);
      req      = j.req;
      acc_done = 1'b0;
      @(negedge clk);
      w  = idx_of(j.exp_gnt);
      rb = 64'h1000 + 64'(w) * 64'h100;
      wb = 64'h2000 + 64'(w) * 64'h100;
      check("gnt", gnt, j.exp_gnt);
      check("acc_read_base", acc_read_base, rb);
      check("acc_write_base", acc_write_base, wb);
      check("acc_num_read", acc_num_read, j.num);
      check("busy_on_grant", busy, 1);
      if (j.num == 0) begin
         check("zero_ack", ack, j.exp_gnt);
         check("zero_err", err, 0);
         check("zero_result", result, 0);
         check("zero_job_count", job_count, j.exp_count);
         check("zero_acc_reset", acc_reset, 1);
         @(negedge clk);
         check("zero_ack_drop", ack, 0);
         check("zero_gnt_drop", gnt, 0);
         check("zero_acc_reset_after", acc_reset, 1);
         check("zero_busy_after", busy, 0);
         return;
      end
      if (j.drop) begin
         req           = '0;
         req_read_base = {NREQ{64'hDEAD_BEEF_0000_0000}};
      end
      cnt = 0;
      while (acc_reset && cnt < 10) begin
         cnt++;
         @(negedge clk);
      end
      check("acc_reset_cycles", 64'(cnt), 64'(RST_CYCLES));
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < TIMEOUT + 8) begin
         cyc++;
         if (cyc == j.delay) begin
            acc_done        = 1'b1;
            acc_returnvalue = j.ret;
         end else begin
            acc_done        = 1'b0;
            acc_returnvalue = ~j.ret;
         end
         @(negedge clk);
         seen = ((ack | err) != '0);
      end
      acc_done = 1'b0;
      check("run_cycles", 64'(cyc), j.exp_err ? 64'(TIMEOUT) : 64'(j.delay));
      check("ack", ack, j.exp_err ? 4'b0000 : j.exp_gnt);
      check("err", err, j.exp_err ? j.exp_gnt : 4'b0000);
      check("result", result, j.exp_result);
      check("job_count", job_count, j.exp_count);
      check("gnt_held", gnt, j.exp_gnt);
      check("desc_held", acc_read_base, rb);
      check("acc_reset_run", acc_reset, 0);
      @(negedge clk);
      check("ack_drop", ack, 0);
      check("err_drop", err, 0);
      check("gnt_drop", gnt, 0);
      check("acc_reset_rise", acc_reset, 1);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      jobs[0]  = '{4'b0001, 64'd8, 1'b1, 20, 32'h55, 4'b0001, 1'b0, 32'h55, 32'd1};
      jobs[1]  = '{4'b1111, 64'd8, 1'b0, 3,  32'hA1, 4'b0010, 1'b0, 32'hA1, 32'd2};
      jobs[2]  = '{4'b1111, 64'd8, 1'b0, 1,  32'hA2, 4'b0100, 1'b0, 32'hA2, 32'd3};
      jobs[3]  = '{4'b1111, 64'd8, 1'b0, 5,  32'hA3, 4'b1000, 1'b0, 32'hA3, 32'd4};
      jobs[4]  = '{4'b1111, 64'd8, 1'b0, 2,  32'hA4, 4'b0001, 1'b0, 32'hA4, 32'd5};
      jobs[5]  = '{4'b1111, 64'd8, 1'b0, -1, 32'hBAD, 4'b0010, 1'b1, 32'hA4, 32'd5};
      jobs[6]  = '{4'b1111, 64'd8, 1'b0, 4,  32'hB6, 4'b0100, 1'b0, 32'hB6, 32'd6};
      jobs[7]  = '{4'b0100, 64'd0, 1'b0, 0,  32'h0,  4'b0100, 1'b0, 32'h0,  32'd7};
      jobs[8]  = '{4'b1000, 64'd8, 1'b0, TIMEOUT,     32'hC8, 4'b1000, 1'b0, 32'hC8, 32'd8};
      jobs[9]  = '{4'b0101, 64'd8, 1'b0, TIMEOUT - 1, 32'hD9, 4'b0001, 1'b0, 32'hD9, 32'd9};
      jobs[10] = '{4'b0101, 64'd8, 1'b0, 2,  32'hDA, 4'b0100, 1'b0, 32'hDA, 32'd10};

      reset           = 1'b0;
      req             = '0;
      acc_done        = 1'b0;
      acc_returnvalue = '0;
      set_desc(64'd8);
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_ack", ack, 0);
      check("rst_err", err, 0);
      check("rst_result", result, 0);
      check("rst_acc_reset", acc_reset, 1);
      check("rst_acc_read_base", acc_read_base, 0);
      check("rst_job_count", job_count, 0);
      check("rst_busy", busy, 0);
      reset = 1'b1;

      for (int i = 0; i < 11; i++) run_job(jobs[i]);

      // Reset five cycles into RUN: job vanishes silently and the pointer restarts at 0.
      req = 4'b1111;
      set_desc(64'd8);
      @(negedge clk);
      check("mid_gnt", gnt, 4'b1000);
      n = 0;
      while (acc_reset && n < 10) begin
         n++;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      check("mid_busy", busy, 1);
      reset           = 1'b0;
      acc_done        = 1'b1;
      acc_returnvalue = 32'h77;
      @(negedge clk);
      check("mid_rst_gnt", gnt, 0);
      check("mid_rst_ack", ack, 0);
      check("mid_rst_err", err, 0);
      check("mid_rst_result", result, 0);
      check("mid_rst_acc_reset", acc_reset, 1);
      check("mid_rst_acc_write_base", acc_write_base, 0);
      check("mid_rst_acc_num_read", acc_num_read, 0);
      check("mid_rst_job_count", job_count, 0);
      check("mid_rst_busy", busy, 0);
      reset    = 1'b1;
      acc_done = 1'b0;
      run_job('{4'b1111, 64'd8, 1'b0, 3, 32'hEE, 4'b0001, 1'b0, 32'hEE, 32'd1});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
